// File: rtl/key_schedule_if.sv
// Round-key stream, start/key control and shared S-box port of the AES-128 key schedule sequencer.
interface key_schedule_if;
   logic         i_start;
   logic [127:0] i_key;
   logic         o_busy;
   logic         o_rkValid;
   logic         i_rkReady;
   logic [127:0] o_roundKey;
   logic [3:0]   o_rkIndex;
   logic         o_sboxReq;
   logic [31:0]  o_sboxIn;
   logic [31:0]  i_sboxOut;
   logic         o_done;

   modport slave (
      input  i_start, i_key, i_rkReady, i_sboxOut,
      output o_busy, o_rkValid, o_roundKey, o_rkIndex, o_sboxReq, o_sboxIn, o_done
   );

   modport master (
      output i_start, i_key, i_rkReady, i_sboxOut,
      input  o_busy, o_rkValid, o_roundKey, o_rkIndex, o_sboxReq, o_sboxIn, o_done
   );
endinterface

// File: rtl/key_schedule_controller.sv
// Iterative AES-128 key expansion: emits round keys 0..10 one per handshake, using an
// external shared S-box whose result arrives SBOX_LAT cycles after the request word.
module key_schedule_controller #(
   parameter int unsigned SBOX_LAT = 0
) (
   input logic           i_clk,
   input logic           i_rst_n,
   key_schedule_if.slave ks
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OUT  = 2'd1,
      ST_SUB  = 2'd2
   } state_t;

   localparam logic [1:0] LAST_WAIT  = SBOX_LAT[1:0];
   localparam logic [3:0] LAST_INDEX = 4'd10;

   state_t       state_r, state_nxt_s;
   logic [127:0] key_r, key_nxt_s;
   logic [7:0]   rcon_r, rcon_nxt_s;
   logic [3:0]   index_r, index_nxt_s;
   logic [1:0]   wait_r, wait_nxt_s;
   logic [31:0]  t_s, sbox_in_nxt_s;
   logic         done_nxt_s;
   logic         busy_r, rk_valid_r, sbox_req_r, done_r;
   logic [31:0]  sbox_in_r;

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] chain_xor(input logic [127:0] k, input logic [31:0] t);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Next-state, key-update and output-register input logic.
   always_comb begin
      state_nxt_s = state_r;
      key_nxt_s   = key_r;
      rcon_nxt_s  = rcon_r;
      index_nxt_s = index_r;
      wait_nxt_s  = wait_r;
      done_nxt_s  = 1'b0;
      t_s         = ks.i_sboxOut ^ {rcon_r, 24'h000000};
      case (state_r)
         ST_IDLE: begin
            if (ks.i_start) begin
               key_nxt_s   = ks.i_key;
               index_nxt_s = 4'd0;
               rcon_nxt_s  = 8'h01;
               wait_nxt_s  = 2'd0;
               state_nxt_s = ST_OUT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (ks.i_rkReady) begin
               if (index_r == LAST_INDEX) begin
                  state_nxt_s = ST_IDLE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_SUB;
                  wait_nxt_s  = 2'd0;
               end
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         ST_SUB: begin
            // The S-box result is only trusted on the final SUB cycle.
            if (wait_r == LAST_WAIT) begin
               key_nxt_s   = chain_xor(key_r, t_s);
               index_nxt_s = index_r + 4'd1;
               rcon_nxt_s  = xtime(rcon_r);
               wait_nxt_s  = 2'd0;
               state_nxt_s = ST_OUT;
            end else begin
               wait_nxt_s  = wait_r + 2'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (state_nxt_s == ST_SUB) begin
         sbox_in_nxt_s = rot_word(key_nxt_s[31:0]);
      end else begin
         sbox_in_nxt_s = 32'h0000_0000;
      end
   end

   // Sequencer state and key/round-constant registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         key_r   <= 128'h0;
         rcon_r  <= 8'h01;
         index_r <= 4'd0;
         wait_r  <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         key_r   <= key_nxt_s;
         rcon_r  <= rcon_nxt_s;
         index_r <= index_nxt_s;
         wait_r  <= wait_nxt_s;
      end
   end

   // Registered status and S-box request outputs, decoded from the next state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_r     <= 1'b0;
         rk_valid_r <= 1'b0;
         sbox_req_r <= 1'b0;
         sbox_in_r  <= 32'h0000_0000;
         done_r     <= 1'b0;
      end else begin
         busy_r     <= (state_nxt_s != ST_IDLE);
         rk_valid_r <= (state_nxt_s == ST_OUT);
         sbox_req_r <= (state_nxt_s == ST_SUB);
         sbox_in_r  <= sbox_in_nxt_s;
         done_r     <= done_nxt_s;
      end
   end

   assign ks.o_busy     = busy_r;
   assign ks.o_rkValid  = rk_valid_r;
   assign ks.o_roundKey = key_r;
   assign ks.o_rkIndex  = index_r;
   assign ks.o_sboxReq  = sbox_req_r;
   assign ks.o_sboxIn   = sbox_in_r;
   assign ks.o_done     = done_r;
endmodule

// File: tb/tb_key_schedule_controller.sv
// Bench for key_schedule_controller: two instances (S-box latency 0 and 2) share stimulus,
// with a key-expansion model feeding a scoreboard plus fixed known-answer vectors.
module tb_key_schedule_controller;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key;
   logic         ready;
   int           tests = 0;
   int           fails = 0;
   int           ec = 0;
   int           start_ec = 0;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   typedef struct {
      logic [127:0] key;
      logic [127:0] k1;
      logic [127:0] k10;
      logic [31:0]  sbox0;
   } vec_t;

   exp_t         q0[$];
   exp_t         q2[$];
   vec_t         vecs[2];
   int           hs[2], dn[2], t10[2], tdone[2], run_len[2];
   logic [127:0] cap[2][11];
   logic         prev_stall[2], prev_req[2], got_first[2];
   logic [127:0] prev_key[2];
   logic [3:0]   prev_idx[2];
   logic [31:0]  prev_in[2], first_in[2];
   logic [31:0]  p1, p2;

   key_schedule_if if0();
   key_schedule_if if2();

   key_schedule_controller #(.SBOX_LAT(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .ks(if0));
   key_schedule_controller #(.SBOX_LAT(2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .ks(if2));

   always #5 clk = ~clk;
   always @(posedge clk) ec <= ec + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox8(input logic [7:0] x);
      logic [7:0] r, s, v;
      r = 8'h01; s = x;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      v = (x == 8'h00) ? 8'h00 : r;
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon_f(input int n);
      case (n)
         1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
         5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
         9: return 8'h1b; 10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign if0.i_start = start;  assign if2.i_start = start;
   assign if0.i_key = key;      assign if2.i_key = key;
   assign if0.i_rkReady = ready; assign if2.i_rkReady = ready;
   assign if0.i_sboxOut = sub_word(if0.o_sboxIn);

   // Two-cycle delayed S-box for the SBOX_LAT=2 instance
   always @(posedge clk) begin
      p1 <= sub_word(if2.o_sboxIn);
      p2 <= p1;
   end
   assign if2.i_sboxOut = p2;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endtask

   task automatic push_expected(input logic [127:0] k);
      logic [31:0] w[44];
      logic [31:0] t;
      exp_t        e;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_f(i / 4), 24'h000000};
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) begin
         e.idx = 4'(r);
         e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         q0.push_back(e);
         q2.push_back(e);
      end
   endtask

   task automatic mon(input int d, input logic v, input logic rdy, input logic busy, input logic done,
                      input logic req, input logic [127:0] rk, input logic [3:0] idx, input logic [31:0] sin);
      exp_t e;
      int   cyc;
      cyc = ec - start_ec;
      if (v && rdy) begin
         hs[d]++;
         if ((d == 0 && q0.size() == 0) || (d == 1 && q2.size() == 0)) begin
            tests++; fails++;
            $display("FAIL unexpected_handshake: dut %0d index %0d with empty scoreboard", d, idx);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q2.pop_front();
            check("round_key", rk, e.key);
            check("rk_index", 128'(idx), 128'(e.idx));
         end
         if (int'(idx) <= 10) cap[d][int'(idx)] = rk;
         if (idx == 4'd10) t10[d] = cyc;
      end
      if (prev_stall[d]) begin
         check("stall_valid", 128'(v), 128'(1'b1));
         check("stall_key", rk, prev_key[d]);
         check("stall_index", 128'(idx), 128'(prev_idx[d]));
      end
      prev_stall[d] = v && !rdy;
      prev_key[d] = rk;
      prev_idx[d] = idx;
      if (req) begin
         if (prev_req[d]) check("sbox_in_stable", 128'(sin), 128'(prev_in[d]));
         if (!got_first[d]) begin
            first_in[d] = sin;
            got_first[d] = 1'b1;
         end
         run_len[d]++;
      end else begin
         check("sbox_in_idle", 128'(sin), 128'h0);
         if (prev_req[d]) check_int("sub_length", run_len[d], (d == 0) ? 1 : 3);
         run_len[d] = 0;
      end
      prev_req[d] = req;
      prev_in[d] = sin;
      if (done) begin
         dn[d]++;
         tdone[d] = cyc;
         check("busy_at_done", 128'(busy), 128'h0);
      end
   endtask

   // Output monitor sampled on the inactive clock edge
   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, if0.o_rkValid, if0.i_rkReady, if0.o_busy, if0.o_done, if0.o_sboxReq,
             if0.o_roundKey, if0.o_rkIndex, if0.o_sboxIn);
         mon(1, if2.o_rkValid, if2.i_rkReady, if2.o_busy, if2.o_done, if2.o_sboxReq,
             if2.o_roundKey, if2.o_rkIndex, if2.o_sboxIn);
      end else begin
         q0.delete();
         q2.delete();
         for (int d = 0; d < 2; d++) begin
            prev_stall[d] = 1'b0;
            prev_req[d] = 1'b0;
            run_len[d] = 0;
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy0"},  128'(if0.o_busy),     128'h0);
      check({tag, "_valid0"}, 128'(if0.o_rkValid),  128'h0);
      check({tag, "_key0"},   if0.o_roundKey,       128'h0);
      check({tag, "_index0"}, 128'(if0.o_rkIndex),  128'h0);
      check({tag, "_req0"},   128'(if0.o_sboxReq),  128'h0);
      check({tag, "_sin0"},   128'(if0.o_sboxIn),   128'h0);
      check({tag, "_done0"},  128'(if0.o_done),     128'h0);
      check({tag, "_busy2"},  128'(if2.o_busy),     128'h0);
      check({tag, "_valid2"}, 128'(if2.o_rkValid),  128'h0);
      check({tag, "_key2"},   if2.o_roundKey,       128'h0);
      check({tag, "_index2"}, 128'(if2.o_rkIndex),  128'h0);
      check({tag, "_req2"},   128'(if2.o_sboxReq),  128'h0);
      check({tag, "_sin2"},   128'(if2.o_sboxIn),   128'h0);
      check({tag, "_done2"},  128'(if2.o_done),     128'h0);
   endtask

   task automatic launch(input logic [127:0] k);
      for (int d = 0; d < 2; d++) begin
         hs[d] = 0; dn[d] = 0; t10[d] = -1; tdone[d] = -1; got_first[d] = 1'b0;
         for (int r = 0; r < 11; r++) cap[d][r] = 128'h0;
      end
      push_expected(k);
      @(posedge clk); #1;
      key = k; start = 1'b1; ready = 1'b1; start_ec = ec;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_sched(input logic [127:0] k, input bit stall, input bit disturb);
      int budget;
      int stall_left;
      budget = 0;
      stall_left = 0;
      launch(k);
      while (!(dn[0] > 0 && dn[1] > 0) && budget < 600) begin
         if (stall) begin
            if (stall_left > 0) begin
               ready = 1'b0;
               stall_left--;
            end else begin
               ready = 1'b1;
               stall_left = $urandom_range(0, 5);
            end
         end
         if (disturb && (budget == 8 || budget == 15)) begin
            start = 1'b1;
            key = ~key;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         budget++;
      end
      start = 1'b0;
      ready = 1'b1;
      if (budget >= 600) begin
         tests++; fails++;
         $display("FAIL run_timeout: done not seen within %0d cycles", budget);
      end
      repeat (3) @(posedge clk);
      #1;
      check_int("handshakes_lat0", hs[0], 11);
      check_int("handshakes_lat2", hs[1], 11);
      check_int("done_count_lat0", dn[0], 1);
      check_int("done_count_lat2", dn[1], 1);
      check_int("scoreboard_left_lat0", q0.size(), 0);
      check_int("scoreboard_left_lat2", q2.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  k1: 128'ha0fafe1788542cb123a339392a6c7605,
                  k10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, sbox0: 32'hcf4f3c09};
      vecs[1] = '{key: 128'h0,
                  k1: 128'h62636363626363636263636362636363,
                  k10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e, sbox0: 32'h00000000};
      rst_n = 1'b0; start = 1'b0; key = 128'h0; ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      for (int v = 0; v < 2; v++) begin
         run_sched(vecs[v].key, 1'b0, 1'b0);
         for (int d = 0; d < 2; d++) begin
            check("key_index0", cap[d][0], vecs[v].key);
            check("key_index1", cap[d][1], vecs[v].k1);
            check("key_index10", cap[d][10], vecs[v].k10);
            check("first_sbox_in", 128'(first_in[d]), 128'(vecs[v].sbox0));
         end
         check_int("key10_cycle_lat0", t10[0], 21);
         check_int("key10_cycle_lat2", t10[1], 41);
         check_int("done_cycle_lat0", tdone[0], 22);
         check_int("done_cycle_lat2", tdone[1], 42);
      end

      // Random backpressure plus start pulses and key changes while busy
      run_sched(vecs[0].key, 1'b1, 1'b1);
      check("stall_key10_lat0", cap[0][10], vecs[0].k10);
      check("stall_key10_lat2", cap[1][10], vecs[0].k10);

      // Asynchronous reset in the middle of round 4's S-box phase
      launch(vecs[0].key);
      budget = 0;
      while (!(if2.o_sboxReq && if2.o_rkIndex == 4'd3) && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      if (budget >= 200) begin
         tests++; fails++;
         $display("FAIL reach_round4_sub: not reached within %0d cycles", budget);
      end
      #2 rst_n = 1'b0;
      #1 check_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_int("midreset_done_lat0", dn[0], 0);
      check_int("midreset_done_lat2", dn[1], 0);
      check("midreset_idle_busy0", 128'(if0.o_busy), 128'h0);
      check("midreset_idle_busy2", 128'(if2.o_busy), 128'h0);

      run_sched(vecs[0].key, 1'b0, 1'b0);
      check("rerun_key1", cap[1][1], vecs[0].k1);
      check("rerun_key10", cap[1][10], vecs[0].k10);
      check_int("rerun_key10_cycle_lat2", t10[1], 41);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/key_schedule_controller.md
Name: key_schedule_controller

Overview:
- Iterative AES-128 key-expansion sequencer. Produces round keys 0..10 one at a time over a valid/ready stream.
- Implements the G-function sequence itself: RotWord on w3, SubWord via an external shared S-box port, Rcon XOR, then the word-chain XORs.
- The S-box is a shared resource with configurable latency, so this block owns the request/capture timing.
- Sits between the top-level AES control and the round datapath's AddRoundKey.

Parameters:
- SBOX_LAT, 0, S-box latency in clock cycles from o_sboxIn to a valid i_sboxOut. Legal values 0..3.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_key  input  128  cipher key; word0 = [127:96]; byte0 = MSB of each word.
- o_busy  output  1  high in every state except IDLE.
- o_rkValid  output  1  round key valid (OUT state).
- i_rkReady  input  1  consumer accepts the round key.
- o_roundKey  output  128  current round key {w0,w1,w2,w3}.
- o_rkIndex  output  4  round index 0..10 of o_roundKey.
- o_sboxReq  output  1  S-box request; high throughout SUB.
- o_sboxIn  output  32  RotWord(w3) = {w3[23:0], w3[31:24]} in SUB; 0 otherwise.
- i_sboxOut  input  32  S-box result, bytewise SubBytes of o_sboxIn.
- o_done  output  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (async, asserted low): state=IDLE, all outputs 0, key register 0, rcon=8'h01, index=0, wait counter=0.
- States: IDLE, OUT, SUB.
- IDLE:
  - i_start=1 loads i_key into the key register, index=0, rcon=01, then goes to OUT.
  - i_start while not in IDLE is ignored.
- OUT:
  - o_rkValid=1; o_roundKey and o_rkIndex are held stable while i_rkReady=0.
  - On handshake (o_rkValid & i_rkReady) with index<10: go to SUB.
  - On handshake with index==10: go to IDLE and pulse o_done next cycle (o_done is high in the first IDLE cycle).
- SUB:
  - Lasts exactly SBOX_LAT+1 cycles, counted by the wait counter.
  - o_sboxIn is held constant for the whole state.
  - In the last SUB cycle, i_sboxOut is sampled and T = i_sboxOut ^ {rcon,24'h0}.
  - Next key: w0'=w0^T, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Also in the last cycle: index+=1; rcon=xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0); go to OUT.
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Latency:
  - Start to round key 0 valid: 1 cycle.
  - Handshake to next valid: SBOX_LAT+2 cycles.
  - With i_rkReady held at 1, key k is valid at cycle 1+k*(SBOX_LAT+2) after the start-sample cycle.
- Backpressure: unlimited stall in OUT; no other state stalls.
- Reset mid-operation aborts immediately to IDLE. No partial key or o_done is emitted.
- i_key changes after the start cycle have no effect.
- o_busy=0 in the same cycle o_done=1. A new start may be sampled in that cycle.

Test Plan:
- SBOX_LAT=0, i_rkReady=1, i_key=2b7e151628aed2a6abf7158809cf4f3c, start at cycle 0 -> required outputs:
  - index1 key = a0fafe1788542cb123a339392a6c7605 at cycle 3.
  - index10 key = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 21.
  - o_done at cycle 22.
- Same key, SBOX_LAT=2 with a delayed S-box model -> same 11 keys; index10 at cycle 41; o_sboxIn stable for 3 cycles per SUB; first o_sboxIn = cf4f3c09.
- Random i_rkReady stalls (up to 5 cycles) -> o_roundKey and o_rkIndex stable during stalls; key sequence identical; exactly 11 handshakes.
- i_start pulsed while busy, and i_key changed mid-run -> no restart; outputs unchanged from the stall-free run.
- i_rst_n asserted asynchronously during SUB of round 4 -> all outputs 0 immediately; no o_done. A fresh start then yields the correct full sequence.
- Key all-zero -> index1 = 62636363626363636263636362636363; index10 = b4ef5bcb3e92e21123e951cf6f8f188e.
